lsu_mem_port: RTL
=================

Name: lsu_mem_port

Overview:
Load/store unit between the execute stage and the data-memory bus of the RV32I core. It takes one decoded load/store per transaction, tagged with the shared memory access width encoding (BYTE/HALF_WORD/WORD/DOUBLE_WORD) and the funct3[2] unsigned bit. It drives a word-aligned memory request with byte enables and waits for the load response. It returns the extended load data, a store-done indication, or a misaligned/illegal-access exception to writeback.

Parameters:
XLEN, 32, data width; only 32 is supported.
ADDR_W, 32, byte address width.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  execute presents a load or store
in_ready  out  1  LSU can accept (state IDLE)
in_is_store  in  1  1 = store, 0 = load
in_size  in  2  memory access width: 00 BYTE, 01 HALF_WORD, 10 WORD, 11 DOUBLE_WORD
in_unsigned  in  1  funct3[2]; zero-extend the load
in_addr  in  ADDR_W  effective byte address
in_wdata  in  XLEN  store data, right-justified
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  word address {addr[31:2],2'b00}
mem_we  out  1  write enable
mem_be  out  4  byte enables
mem_wdata  out  XLEN  lane-replicated store data
mem_rsp_valid  in  1  load data valid
mem_rdata  in  XLEN  full word read data
done_valid  out  1  one-cycle completion pulse to writeback
done_data  out  XLEN  extended load result (0 for stores and exceptions)
done_exc  out  1  misaligned or illegal access
done_exc_addr  out  ADDR_W  faulting byte address

Behaviour:
- Clock and reset: single clock `clk`; `rst_n` is asynchronous and active-low.
- States: IDLE, REQ, WAIT_RSP, DONE, EXC. Only one transaction is outstanding at a time.
- Reset state: IDLE. All outputs reset to 0 except `in_ready`, which is 1 in IDLE.
- Accept: `in_valid && in_ready` in IDLE latches is_store, size, unsigned, addr and wdata.
- Alignment check at accept:
  - HALF_WORD with addr[0]=1 is misaligned.
  - WORD with addr[1:0]≠0 is misaligned.
  - DOUBLE_WORD is always illegal (RV32).
  - Misaligned or illegal -> EXC; otherwise -> REQ.
- EXC: for exactly one cycle, `done_valid=1`, `done_exc=1`, `done_exc_addr` = latched address, `done_data=0`. Next state IDLE. `mem_req_valid` is never asserted for this transaction.
- REQ:
  - Outputs: `mem_req_valid=1`, `mem_addr` = word address, `mem_we` = is_store.
  - `mem_be`: BYTE gives 1<<addr[1:0]; HALF gives 2'b11<<addr[1:0]; WORD gives 4'hF.
  - `mem_wdata`: byte replicated x4, or half replicated x2, or the full word.
  - All request outputs are held stable until `mem_req_ready`.
  - On handshake: a store goes to DONE; a load goes to WAIT_RSP.
- WAIT_RSP:
  - `mem_req_valid=0`. Wait any number of cycles for `mem_rsp_valid`.
  - On `mem_rsp_valid`, select the byte/half lane by addr[1:0]. Sign-extend, or zero-extend when `in_unsigned`.
  - Register the result into `done_data` and go to DONE.
- DONE: `done_valid=1` for one cycle, `done_exc=0`; next state IDLE. Writeback cannot stall; `done_valid` is a pulse.
- Latency:
  - Store: `done_valid` one cycle after the request handshake.
  - Load: `done_valid` one cycle after `mem_rsp_valid`.
  - Exception: `done_valid` one cycle after accept.
  - Minimum accept-to-accept for a load with zero-wait memory: 4 cycles.
- `mem_rsp_valid` outside WAIT_RSP is ignored; no state change.
- `in_valid` while not IDLE is ignored; `in_ready=0`.
- Reset mid-operation: returns to IDLE immediately and clears all outputs. An in-flight memory transaction is abandoned; a late response arriving in IDLE is ignored.
- Width rules: unused lanes of `mem_wdata` carry replicated data, never X. `done_data` is always a full XLEN value.

Test Plan:
- Byte store: SB, addr 0x1003, wdata 0x000000A5, `mem_req_ready=1` -> `mem_addr` 0x1000, `mem_be` 4'b1000, `mem_wdata` 0xA5A5A5A5, `mem_we=1`; `done_valid` pulses one cycle after the handshake with `done_exc=0`.
- Byte load extension: LB addr 0x2002 with `mem_rdata` 0x12F45678 -> `done_data` 0xFFFFFFF4. LBU, same inputs -> 0x000000F4.
- Half load extension: LH addr 0x2002 with `mem_rdata` 0x80015678 -> 0xFFFF8001. LHU -> 0x00008001. `mem_be` 4'b1100 in both cases.
- Misaligned/illegal: LW addr 0x2006 -> `mem_req_valid` stays 0; `done_valid`, `done_exc` = 1 one cycle after accept; `done_exc_addr` 0x2006. DOUBLE_WORD at 0x3000 gives the same exception response.
- Request stall: SH addr 0x4000, wdata 0xBEEF, `mem_req_ready` low for 3 cycles -> `mem_addr`, `mem_be` (4'b0011) and `mem_wdata` (0xBEEFBEEF) stay stable; `in_ready=0` throughout; a second `in_valid` during the stall is ignored.
- Reset mid-operation: assert `rst_n=0` during WAIT_RSP, then deliver `mem_rsp_valid` after release -> state IDLE, `done_valid` never pulses, `in_ready=1`.

Source files
------------

// File: rtl/lsu_mem_port.sv
// RV32I load/store unit: turns one decoded load/store into a word-aligned bus request
// and returns the extended load data, a store completion, or an access exception.
module lsu_mem_port #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_store,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              done_valid,
    output logic [XLEN-1:0]   done_data,
    output logic              done_exc,
    output logic [ADDR_W-1:0] done_exc_addr
);

    typedef enum logic [2:0] {StIdle, StReq, StWaitRsp, StDone, StExc} state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic              r_is_store;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_ldata;

    logic              w_bad;
    logic [3:0]        w_be;
    logic [XLEN-1:0]   w_wdata;
    logic [7:0]        w_lane_byte;
    logic [15:0]       w_lane_half;
    logic [XLEN-1:0]   w_load;

    // Alignment is judged on the incoming request so EXC is entered straight from IDLE.
    always_comb begin
        w_bad = 1'b0;
        unique case (in_size)
            2'b00: w_bad = 1'b0;
            2'b01: w_bad = in_addr[0];
            2'b10: w_bad = (in_addr[1:0] != 2'b00);
            2'b11: w_bad = 1'b1;
        endcase
    end

    always_comb begin
        w_be    = 4'hF;
        w_wdata = r_wdata;
        unique case (r_size)
            2'b00: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << r_addr[1:0];
                w_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'hF;
                w_wdata = r_wdata;
            end
        endcase
    end

    always_comb begin
        w_lane_byte = mem_rdata[7:0];
        unique case (r_addr[1:0])
            2'b00: w_lane_byte = mem_rdata[7:0];
            2'b01: w_lane_byte = mem_rdata[15:8];
            2'b10: w_lane_byte = mem_rdata[23:16];
            2'b11: w_lane_byte = mem_rdata[31:24];
        endcase
        w_lane_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (r_size)
            2'b00:   w_load = {{24{w_lane_byte[7] & ~r_unsigned}}, w_lane_byte};
            2'b01:   w_load = {{16{w_lane_half[15] & ~r_unsigned}}, w_lane_half};
            default: w_load = mem_rdata;
        endcase
    end

    always_comb begin
        w_state_d     = r_state;
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        mem_addr      = '0;
        mem_we        = 1'b0;
        mem_be        = 4'b0000;
        mem_wdata     = '0;
        done_valid    = 1'b0;
        done_data     = '0;
        done_exc      = 1'b0;
        done_exc_addr = '0;
        unique case (r_state)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) w_state_d = w_bad ? StExc : StReq;
            end
            StReq: begin
                mem_req_valid = 1'b1;
                mem_addr      = {r_addr[ADDR_W-1:2], 2'b00};
                mem_we        = r_is_store;
                mem_be        = w_be;
                mem_wdata     = w_wdata;
                if (mem_req_ready) w_state_d = r_is_store ? StDone : StWaitRsp;
            end
            StWaitRsp: begin
                if (mem_rsp_valid) w_state_d = StDone;
            end
            StDone: begin
                done_valid = 1'b1;
                done_data  = r_ldata;
                w_state_d  = StIdle;
            end
            StExc: begin
                done_valid    = 1'b1;
                done_exc      = 1'b1;
                done_exc_addr = r_addr;
                w_state_d     = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_is_store <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_ldata    <= '0;
        end else begin
            r_state <= w_state_d;
            if (r_state == StIdle && in_valid) begin
                r_is_store <= in_is_store;
                r_size     <= in_size;
                r_unsigned <= in_unsigned;
                r_addr     <= in_addr;
                r_wdata    <= in_wdata;
                r_ldata    <= '0;
            end
            if (r_state == StWaitRsp && mem_rsp_valid) r_ldata <= w_load;
        end
    end

endmodule
